mem_req_responder: RTL

//  Memory-side end of the core's memreq/memresp interface: accepts load/store requests and returns one response per request.

---
 rtl/mem_req_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_req_responder.sv
// Memory-side responder: word memory with byte strobes, fixed-latency in-order responses, credit-protected response FIFO.
// Optional MEM_RESP_RANDOM_STALL_EN adds an LFSR that randomly stalls request acceptance and response delivery.
module mem_req_responder #(
    parameter int N_BITS     = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_val,
    output logic                req_rdy,
    input  logic                req_we,
    input  logic [N_BITS-1:0]   req_addr,
    input  logic [N_BITS-1:0]   req_wdata,
    input  logic [N_BITS/8-1:0] req_wstrb,
    output logic                resp_val,
    input  logic                resp_rdy,
    output logic                resp_we,
    output logic [N_BITS-1:0]   resp_rdata,
    output logic                resp_err
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH) + 1;
    localparam int SW = N_BITS / 8;

    logic [N_BITS-1:0] mem [MEM_WORDS];

    logic              started_q;
    logic [CW-1:0]     out_cnt;
    logic              stall;
    logic              accept;
    logic              push;
    logic              pop;
    logic [AW-1:0]     req_idx;
    logic              req_err;
    logic [N_BITS-1:0] load_data;

`ifdef MEM_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // Credit counts everything accepted but not yet popped, so the FIFO cannot overflow.
    assign req_rdy   = started_q & ~stall & (out_cnt < CW'(RESP_DEPTH));
    assign accept    = req_val & req_rdy;
    assign req_idx   = req_addr[AW+1:2];
    assign req_err   = (req_addr[1:0] != 2'b00) | (|req_addr[N_BITS-1:AW+2]);
    assign load_data = (req_we || req_err) ? '0 : mem[req_idx];

    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err) begin
            for (int b = 0; b < SW; b++) begin
                if (req_wstrb[b]) mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    // Stage p0..p(LATENCY-1): fixed-latency response pipeline
    logic              vld_p   [LATENCY];
    logic              we_p    [LATENCY];
    logic              err_p   [LATENCY];
    logic [N_BITS-1:0] rdata_p [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        we_p[0]    <= req_we;
        err_p[0]   <= req_err;
        rdata_p[0] <= load_data;
        for (int i = 1; i < LATENCY; i++) begin
            we_p[i]    <= we_p[i-1];
            err_p[i]   <= err_p[i-1];
            rdata_p[i] <= rdata_p[i-1];
        end
    end

    // Response FIFO: last pipeline stage pushes, requester pops
    logic              fifo_we    [RESP_DEPTH];
    logic              fifo_err   [RESP_DEPTH];
    logic [N_BITS-1:0] fifo_rdata [RESP_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_has;

    assign push     = vld_p[LATENCY-1];
    assign fifo_has = (fifo_cnt != '0);
    assign resp_val = fifo_has & ~stall;
    assign pop      = resp_val & resp_rdy;

    // Payload is gated on occupancy, not on stall, so it stays stable across stalled cycles.
    assign resp_we    = fifo_has & fifo_we[rd_ptr];
    assign resp_err   = fifo_has & fifo_err[rd_ptr];
    assign resp_rdata = fifo_has ? fifo_rdata[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr]    <= we_p[LATENCY-1];
            fifo_err[wr_ptr]   <= err_p[LATENCY-1];
            fifo_rdata[wr_ptr] <= rdata_p[LATENCY-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
            out_cnt   <= '0;
            fifo_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            started_q <= 1'b1;
            out_cnt   <= out_cnt + CW'(accept) - CW'(pop);
            fifo_cnt  <= fifo_cnt + CW'(push) - CW'(pop);
            if (push) wr_ptr <= (wr_ptr == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_latency_range: assert property (@(posedge clk) (LATENCY >= 1) && (LATENCY <= 4));
    a_depth_vs_lat:  assert property (@(posedge clk) RESP_DEPTH >= LATENCY);
    a_no_overflow:   assert property (@(posedge clk) disable iff (!rst_n)
                         !(push && !pop && (fifo_cnt == CW'(RESP_DEPTH))));
    a_req_stable:    assert property (@(posedge clk) disable iff (!rst_n)
                         (req_val && !req_rdy) |=> (req_val && $stable(req_we) && $stable(req_addr)
                                                    && $stable(req_wdata) && $stable(req_wstrb)));
`endif
endmodule
